// File: rtl/lrwait_mqnode.sv
// Multi-slot LRWait/SCWait queue node between a Snitch core and the tile interconnect.
// Each slot tracks one reservation and injects the WakeUp that hands the lock to its successor.
module lrwait_mqnode #(
   parameter int unsigned NumSlots  = 2,
   parameter int unsigned MetaWidth = 12,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter type         meta_id_t = logic [7:0]
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [AddrWidth-1:0] snitch_qaddr_i,
   input  logic                 snitch_qwrite_i,
   input  logic [3:0]           snitch_qamo_i,
   input  logic [DataWidth-1:0] snitch_qdata_i,
   input  logic [3:0]           snitch_qstrb_i,
   input  meta_id_t             snitch_qid_i,
   input  logic                 snitch_qvalid_i,
   output logic                 snitch_qready_o,
   output logic [DataWidth-1:0] snitch_pdata_o,
   output logic                 snitch_perror_o,
   output meta_id_t             snitch_pid_o,
   output logic                 snitch_pvalid_o,
   input  logic                 snitch_pready_i,
   output logic [AddrWidth-1:0] tile_qaddr_o,
   output logic                 tile_qwrite_o,
   output logic [3:0]           tile_qamo_o,
   output logic [DataWidth-1:0] tile_qdata_o,
   output logic [3:0]           tile_qstrb_o,
   output meta_id_t             tile_qid_o,
   output logic                 tile_qlrwait_o,
   output logic                 tile_qvalid_o,
   input  logic                 tile_qready_i,
   input  logic [DataWidth-1:0] tile_pdata_i,
   input  logic                 tile_perror_i,
   input  meta_id_t             tile_pid_i,
   input  logic                 tile_plrwait_i,
   input  logic                 tile_pvalid_i,
   output logic                 tile_pready_o,
   output logic [NumSlots-1:0]  busy_o,
   output logic                 error_o
);

   localparam logic [3:0]  AmoLrWait = 4'hC;
   localparam logic [3:0]  AmoScWait = 4'hD;
   localparam int unsigned IdxW      = (NumSlots > 1) ? $clog2(NumSlots) : 1;

   typedef enum logic [2:0] {SlotFree, SlotPending, SlotOwner, SlotSucc, SlotWake} slot_state_e;

   slot_state_e          r_state   [NumSlots];
   logic [AddrWidth-1:0] r_addr    [NumSlots];
   meta_id_t             r_id      [NumSlots];
   logic [MetaWidth-1:0] r_meta    [NumSlots];
   logic                 r_sc_seen [NumSlots];
   logic [IdxW-1:0]      r_rr_ptr;
   logic                 r_hold;
   logic [IdxW-1:0]      r_hold_idx;
   logic                 r_error;

   slot_state_e          w_state_nxt [NumSlots];
   logic [AddrWidth-1:0] w_addr_nxt  [NumSlots];
   meta_id_t             w_id_nxt    [NumSlots];
   logic [MetaWidth-1:0] w_meta_nxt  [NumSlots];
   logic                 w_sc_nxt    [NumSlots];

   logic                 w_any_wake, w_free_any, w_lr_dup, w_lr_stall;
   logic [IdxW-1:0]      w_pick, w_gnt, w_free_idx;
   logic [NumSlots-1:0]  w_addr_hit, w_sc_hit, w_su_hit;
   logic                 w_req_lr, w_req_sc, w_req_hs, w_lr_alloc, w_sc_orphan;
   logic                 w_p_hs, w_su, w_nr, w_su_orphan, w_inj_hs;
   logic [DataWidth-1:0] w_meta_ext;

   // r_rr_ptr names the slot with highest priority; it advances past each granted slot.
   function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base, input int unsigned k);
      int unsigned s;
      s = (32'(base) + k) % NumSlots;
      return IdxW'(s);
   endfunction

   always_comb begin
      w_any_wake = 1'b0;
      w_pick     = r_rr_ptr;
      w_free_any = 1'b0;
      w_free_idx = '0;
      w_addr_hit = '0;
      for (int k = 0; k < NumSlots; k++) begin
         if (!w_any_wake && r_state[rr_idx(r_rr_ptr, k)] == SlotWake) begin
            w_any_wake = 1'b1;
            w_pick     = rr_idx(r_rr_ptr, k);
         end
      end
      for (int i = NumSlots - 1; i >= 0; i--) begin
         if (r_state[i] == SlotFree) begin
            w_free_any = 1'b1;
            w_free_idx = IdxW'(i);
         end
         w_addr_hit[i] = (r_state[i] != SlotFree) && (r_addr[i] == snitch_qaddr_i);
      end
      w_gnt = r_hold ? r_hold_idx : w_pick;
   end

   assign w_req_lr        = (snitch_qamo_i == AmoLrWait);
   assign w_req_sc        = (snitch_qamo_i == AmoScWait);
   assign w_lr_dup        = w_req_lr && (|w_addr_hit);
   assign w_lr_stall      = w_req_lr && !w_lr_dup && !w_free_any;
   assign snitch_qready_o = !w_any_wake && !w_lr_stall && tile_qready_i;
   assign w_req_hs        = snitch_qvalid_i && snitch_qready_o;
   assign w_lr_alloc      = w_req_hs && w_req_lr && !w_lr_dup;
   assign w_inj_hs        = w_any_wake && tile_qready_i;

   assign tile_pready_o   = tile_plrwait_i ? 1'b1 : snitch_pready_i;
   assign w_p_hs          = tile_pvalid_i && tile_pready_o;
   assign w_su            = w_p_hs && tile_plrwait_i;
   assign w_nr            = w_p_hs && !tile_plrwait_i;
   assign snitch_pvalid_o = tile_pvalid_i && !tile_plrwait_i;
   assign snitch_pdata_o  = tile_pdata_i;
   assign snitch_perror_o = tile_perror_i;
   assign snitch_pid_o    = tile_pid_i;

   always_comb begin
      w_sc_hit = '0;
      w_su_hit = '0;
      for (int i = 0; i < NumSlots; i++) begin
         // Only one SCWAIT is accepted per reservation; a repeat counts as an orphan.
         w_sc_hit[i] = w_req_hs && w_req_sc && w_addr_hit[i] && !r_sc_seen[i] &&
                       (r_state[i] == SlotOwner || r_state[i] == SlotSucc);
         w_su_hit[i] = (r_state[i] == SlotPending || r_state[i] == SlotOwner) &&
                       (r_id[i] == tile_pid_i);
      end
   end

   assign w_sc_orphan = w_req_hs && w_req_sc && !(|w_sc_hit);
   assign w_su_orphan = w_su && !(|w_su_hit);

   always_comb begin
      for (int i = 0; i < NumSlots; i++) begin
         w_state_nxt[i] = r_state[i];
         w_addr_nxt[i]  = r_addr[i];
         w_id_nxt[i]    = r_id[i];
         w_meta_nxt[i]  = r_meta[i];
         w_sc_nxt[i]    = r_sc_seen[i];
         case (r_state[i])
            SlotFree: if (w_lr_alloc && w_free_idx == IdxW'(i)) begin
               w_state_nxt[i] = SlotPending;
               w_addr_nxt[i]  = snitch_qaddr_i;
               w_id_nxt[i]    = snitch_qid_i;
               w_sc_nxt[i]    = 1'b0;
            end
            SlotPending: if (w_p_hs && tile_pid_i == r_id[i]) begin
               if (tile_plrwait_i) begin
                  w_state_nxt[i] = SlotSucc;
                  w_meta_nxt[i]  = tile_pdata_i[MetaWidth-1:0];
               end else begin
                  w_state_nxt[i] = SlotOwner;
               end
            end
            SlotOwner: begin
               // The SC's qid replaces the LR id so its response can be recognised.
               if (w_sc_hit[i]) begin
                  w_sc_nxt[i] = 1'b1;
                  w_id_nxt[i] = snitch_qid_i;
               end
               if (w_su && tile_pid_i == r_id[i]) begin
                  w_meta_nxt[i]  = tile_pdata_i[MetaWidth-1:0];
                  w_state_nxt[i] = (r_sc_seen[i] || w_sc_hit[i]) ? SlotWake : SlotSucc;
               end else if (w_nr && tile_pid_i == r_id[i] && r_sc_seen[i]) begin
                  w_state_nxt[i] = SlotFree;
                  w_sc_nxt[i]    = 1'b0;
               end
            end
            SlotSucc: if (w_sc_hit[i]) w_state_nxt[i] = SlotWake;
            SlotWake: if (w_inj_hs && w_gnt == IdxW'(i)) begin
               w_state_nxt[i] = SlotFree;
               w_sc_nxt[i]    = 1'b0;
            end
            default: w_state_nxt[i] = SlotFree;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NumSlots; i++) begin
            r_state[i]   <= SlotFree;
            r_addr[i]    <= '0;
            r_id[i]      <= '0;
            r_meta[i]    <= '0;
            r_sc_seen[i] <= 1'b0;
         end
         r_rr_ptr   <= '0;
         r_hold     <= 1'b0;
         r_hold_idx <= '0;
         r_error    <= 1'b0;
      end else begin
         for (int i = 0; i < NumSlots; i++) begin
            r_state[i]   <= w_state_nxt[i];
            r_addr[i]    <= w_addr_nxt[i];
            r_id[i]      <= w_id_nxt[i];
            r_meta[i]    <= w_meta_nxt[i];
            r_sc_seen[i] <= w_sc_nxt[i];
         end
         if (w_inj_hs) r_rr_ptr <= (w_gnt == IdxW'(NumSlots - 1)) ? '0 : w_gnt + 1'b1;
         r_hold     <= w_any_wake && !tile_qready_i;
         r_hold_idx <= w_gnt;
         r_error    <= (w_req_hs && w_lr_dup) || w_sc_orphan || w_su_orphan;
      end
   end

   always_comb begin
      w_meta_ext                = '0;
      w_meta_ext[MetaWidth-1:0] = r_meta[w_gnt];
      for (int i = 0; i < NumSlots; i++) busy_o[i] = (r_state[i] != SlotFree);
   end

   // A pending WakeUp owns the tile request port; otherwise the core request passes straight through.
   assign tile_qaddr_o   = w_any_wake ? r_addr[w_gnt] : snitch_qaddr_i;
   assign tile_qwrite_o  = w_any_wake ? 1'b0          : snitch_qwrite_i;
   assign tile_qamo_o    = w_any_wake ? AmoLrWait     : snitch_qamo_i;
   assign tile_qdata_o   = w_any_wake ? w_meta_ext    : snitch_qdata_i;
   assign tile_qstrb_o   = w_any_wake ? 4'h0          : snitch_qstrb_i;
   assign tile_qid_o     = w_any_wake ? r_id[w_gnt]   : snitch_qid_i;
   assign tile_qlrwait_o = w_any_wake;
   assign tile_qvalid_o  = w_any_wake || (snitch_qvalid_i && !w_lr_stall);
   assign error_o        = r_error;

endmodule

// File: tb/tb_lrwait_mqnode.sv
// Directed bench for lrwait_mqnode: pass-through, reservation lifecycle, WakeUp injection,
// round-robin between Wake slots, allocation stall, protocol errors and reset.
module tb_lrwait_mqnode;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [31:0] snitch_qaddr_i;
   logic        snitch_qwrite_i;
   logic [3:0]  snitch_qamo_i;
   logic [31:0] snitch_qdata_i;
   logic [3:0]  snitch_qstrb_i;
   logic [7:0]  snitch_qid_i;
   logic        snitch_qvalid_i;
   logic        snitch_qready_o;
   logic [31:0] snitch_pdata_o;
   logic        snitch_perror_o;
   logic [7:0]  snitch_pid_o;
   logic        snitch_pvalid_o;
   logic        snitch_pready_i;
   logic [31:0] tile_qaddr_o;
   logic        tile_qwrite_o;
   logic [3:0]  tile_qamo_o;
   logic [31:0] tile_qdata_o;
   logic [3:0]  tile_qstrb_o;
   logic [7:0]  tile_qid_o;
   logic        tile_qlrwait_o;
   logic        tile_qvalid_o;
   logic        tile_qready_i;
   logic [31:0] tile_pdata_i;
   logic        tile_perror_i;
   logic [7:0]  tile_pid_i;
   logic        tile_plrwait_i;
   logic        tile_pvalid_i;
   logic        tile_pready_o;
   logic [1:0]  busy_o;
   logic        error_o;

   int checks = 0;
   int errors = 0;

   localparam logic [3:0] LR = 4'hC;
   localparam logic [3:0] SC = 4'hD;

   lrwait_mqnode dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .snitch_qaddr_i(snitch_qaddr_i), .snitch_qwrite_i(snitch_qwrite_i), .snitch_qamo_i(snitch_qamo_i),
      .snitch_qdata_i(snitch_qdata_i), .snitch_qstrb_i(snitch_qstrb_i), .snitch_qid_i(snitch_qid_i),
      .snitch_qvalid_i(snitch_qvalid_i), .snitch_qready_o(snitch_qready_o),
      .snitch_pdata_o(snitch_pdata_o), .snitch_perror_o(snitch_perror_o), .snitch_pid_o(snitch_pid_o),
      .snitch_pvalid_o(snitch_pvalid_o), .snitch_pready_i(snitch_pready_i),
      .tile_qaddr_o(tile_qaddr_o), .tile_qwrite_o(tile_qwrite_o), .tile_qamo_o(tile_qamo_o),
      .tile_qdata_o(tile_qdata_o), .tile_qstrb_o(tile_qstrb_o), .tile_qid_o(tile_qid_o),
      .tile_qlrwait_o(tile_qlrwait_o), .tile_qvalid_o(tile_qvalid_o), .tile_qready_i(tile_qready_i),
      .tile_pdata_i(tile_pdata_i), .tile_perror_i(tile_perror_i), .tile_pid_i(tile_pid_i),
      .tile_plrwait_i(tile_plrwait_i), .tile_pvalid_i(tile_pvalid_i), .tile_pready_o(tile_pready_o),
      .busy_o(busy_o), .error_o(error_o)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks (all return at posedge+1) ----------------
   task automatic cyc();
      @(posedge clk_i); #1;
   endtask

   task automatic apply_reset();
      rst_ni = 1'b0;
      snitch_qvalid_i = 1'b0; tile_pvalid_i = 1'b0;
      tile_qready_i = 1'b1; snitch_pready_i = 1'b1;
      cyc(); cyc();
      rst_ni = 1'b1;
      cyc();
   endtask

   task automatic do_req(input logic [31:0] a, input logic [3:0] amo, input logic [7:0] id);
      logic rdy;
      logic done;
      snitch_qaddr_i = a; snitch_qamo_i = amo; snitch_qid_i = id;
      snitch_qwrite_i = 1'b0; snitch_qdata_i = '0; snitch_qstrb_i = '0;
      snitch_qvalid_i = 1'b1;
      done = 1'b0;
      for (int n = 0; n < 20 && !done; n++) begin
         #1 rdy = snitch_qready_o;
         @(posedge clk_i); #1;
         done = rdy;
      end
      snitch_qvalid_i = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL req_timeout: addr %h not accepted within 20 cycles (required accepted)", a);
      end
   endtask

   task automatic do_resp(input logic [7:0] id, input logic [31:0] d, input logic lrw);
      tile_pid_i = id; tile_pdata_i = d; tile_plrwait_i = lrw; tile_perror_i = 1'b0;
      tile_pvalid_i = 1'b1;
      cyc();
      tile_pvalid_i = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_ni = 1'b0;
      snitch_qaddr_i = 32'h55; snitch_qamo_i = 4'h0; snitch_qid_i = 8'h0; snitch_qwrite_i = 1'b0;
      snitch_qdata_i = '0; snitch_qstrb_i = '0; snitch_qvalid_i = 1'b1;
      tile_qready_i = 1'b1; snitch_pready_i = 1'b1;
      tile_pdata_i = '0; tile_perror_i = 1'b0; tile_pid_i = '0; tile_plrwait_i = 1'b0; tile_pvalid_i = 1'b0;
      #2;
      checks++; if (busy_o !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b required 00", busy_o); end
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL reset_error: got %b required 0", error_o); end
      checks++; if (tile_qlrwait_o !== 1'b0) begin errors++; $display("FAIL reset_qlrwait: got %b required 0", tile_qlrwait_o); end
      checks++; if (tile_qvalid_o !== 1'b1 || tile_qaddr_o !== 32'h55) begin errors++;
         $display("FAIL reset_passthru: got valid %b addr %h required 1 00000055", tile_qvalid_o, tile_qaddr_o); end
      snitch_qvalid_i = 1'b0;
      cyc(); cyc();
      rst_ni = 1'b1;
      cyc();
   endtask

   task automatic test_passthrough();
      snitch_qaddr_i = 32'h100; snitch_qid_i = 8'd3; snitch_qamo_i = 4'h0; snitch_qwrite_i = 1'b0;
      snitch_qdata_i = 32'h1234; snitch_qstrb_i = 4'hF; snitch_qvalid_i = 1'b1;
      #1;
      checks++; if (tile_qaddr_o !== 32'h100 || tile_qid_o !== 8'd3 || tile_qdata_o !== 32'h1234 || tile_qstrb_o !== 4'hF)
         begin errors++; $display("FAIL pt_fields: got addr %h id %0d data %h strb %h", tile_qaddr_o, tile_qid_o, tile_qdata_o, tile_qstrb_o); end
      checks++; if (tile_qlrwait_o !== 1'b0 || tile_qvalid_o !== 1'b1 || snitch_qready_o !== 1'b1)
         begin errors++; $display("FAIL pt_ctrl: got lrw %b valid %b ready %b required 0 1 1", tile_qlrwait_o, tile_qvalid_o, snitch_qready_o); end
      cyc();
      snitch_qvalid_i = 1'b0;
      tile_pid_i = 8'd3; tile_pdata_i = 32'hDEAD; tile_plrwait_i = 1'b0; tile_pvalid_i = 1'b1; snitch_pready_i = 1'b0;
      #1;
      checks++; if (snitch_pvalid_o !== 1'b1 || snitch_pdata_o !== 32'hDEAD || snitch_pid_o !== 8'd3 || tile_pready_o !== 1'b0)
         begin errors++; $display("FAIL pt_resp: got pvalid %b data %h id %0d pready %b required 1 dead 3 0", snitch_pvalid_o, snitch_pdata_o, snitch_pid_o, tile_pready_o); end
      snitch_pready_i = 1'b1;
      cyc();
      tile_pvalid_i = 1'b0;
      checks++; if (busy_o !== 2'b00) begin errors++; $display("FAIL pt_busy: got %b required 00", busy_o); end
   endtask

   task automatic test_lr_normal();
      do_req(32'h40, LR, 8'd1);
      checks++; if (busy_o !== 2'b01) begin errors++; $display("FAIL lrn_busy_alloc: got %b required 01", busy_o); end
      do_resp(8'd1, 32'h0, 1'b0);
      do_req(32'h40, SC, 8'd2);
      checks++; if (busy_o !== 2'b01 || tile_qlrwait_o !== 1'b0) begin errors++;
         $display("FAIL lrn_after_sc: got busy %b lrw %b required 01 0", busy_o, tile_qlrwait_o); end
      do_resp(8'd2, 32'h0, 1'b0);
      checks++; if (busy_o !== 2'b00) begin errors++; $display("FAIL lrn_busy_free: got %b required 00", busy_o); end
      checks++; if (tile_qvalid_o !== 1'b0 || error_o !== 1'b0) begin errors++;
         $display("FAIL lrn_no_wake: got qvalid %b err %b required 0 0", tile_qvalid_o, error_o); end
   endtask

   task automatic test_wakeup();
      do_req(32'h40, LR, 8'd1);
      tile_pid_i = 8'd1; tile_pdata_i = 32'h2A5; tile_plrwait_i = 1'b1; tile_pvalid_i = 1'b1; snitch_pready_i = 1'b0;
      #1;
      checks++; if (tile_pready_o !== 1'b1 || snitch_pvalid_o !== 1'b0) begin errors++;
         $display("FAIL wk_su_consume: got pready %b pvalid %b required 1 0", tile_pready_o, snitch_pvalid_o); end
      cyc();
      tile_pvalid_i = 1'b0; snitch_pready_i = 1'b1;
      do_req(32'h40, SC, 8'd5);
      checks++; if (tile_qvalid_o !== 1'b1 || tile_qamo_o !== 4'hC || tile_qaddr_o !== 32'h40 || tile_qdata_o !== 32'h2A5 ||
                    tile_qlrwait_o !== 1'b1 || tile_qid_o !== 8'd1 || tile_qwrite_o !== 1'b0 || tile_qstrb_o !== 4'h0)
         begin errors++; $display("FAIL wk_beat: got v %b amo %h addr %h data %h lrw %b id %0d required 1 c 40 2a5 1 1",
            tile_qvalid_o, tile_qamo_o, tile_qaddr_o, tile_qdata_o, tile_qlrwait_o, tile_qid_o); end
      tile_qready_i = 1'b0;
      snitch_qaddr_i = 32'h200; snitch_qamo_i = 4'h0; snitch_qid_i = 8'd9; snitch_qvalid_i = 1'b1;
      #1;
      checks++; if (snitch_qready_o !== 1'b0) begin errors++; $display("FAIL wk_core_stall: got ready %b required 0", snitch_qready_o); end
      cyc();
      tile_qready_i = 1'b1;
      #1;
      checks++; if (snitch_qready_o !== 1'b0 || tile_qaddr_o !== 32'h40) begin errors++;
         $display("FAIL wk_own_port: got ready %b addr %h required 0 40", snitch_qready_o, tile_qaddr_o); end
      cyc();
      checks++; if (busy_o !== 2'b00 || tile_qaddr_o !== 32'h200 || tile_qlrwait_o !== 1'b0 || snitch_qready_o !== 1'b1)
         begin errors++; $display("FAIL wk_release: got busy %b addr %h lrw %b ready %b required 00 200 0 1",
            busy_o, tile_qaddr_o, tile_qlrwait_o, snitch_qready_o); end
      cyc();
      snitch_qvalid_i = 1'b0;
      do_resp(8'd5, 32'h0, 1'b0);
   endtask

   task automatic test_two_slots();
      do_req(32'h40, LR, 8'd1);
      do_req(32'h80, LR, 8'd2);
      checks++; if (busy_o !== 2'b11) begin errors++; $display("FAIL two_busy: got %b required 11", busy_o); end
      do_resp(8'd1, 32'h011, 1'b1);
      do_resp(8'd2, 32'h022, 1'b1);
      do_req(32'h40, SC, 8'd3);
      tile_qready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (tile_qvalid_o !== 1'b1 || tile_qaddr_o !== 32'h40 || tile_qdata_o !== 32'h011 || tile_qid_o !== 8'd1)
            begin errors++; $display("FAIL two_hold0 c%0d: got v %b addr %h data %h id %0d required 1 40 11 1",
               c, tile_qvalid_o, tile_qaddr_o, tile_qdata_o, tile_qid_o); end
         cyc();
      end
      tile_qready_i = 1'b1;
      cyc();
      checks++; if (busy_o !== 2'b10) begin errors++; $display("FAIL two_slot0_free: got %b required 10", busy_o); end
      do_req(32'h80, SC, 8'd4);
      checks++; if (tile_qvalid_o !== 1'b1 || tile_qaddr_o !== 32'h80 || tile_qdata_o !== 32'h022 || tile_qid_o !== 8'd2)
         begin errors++; $display("FAIL two_wake1: got v %b addr %h data %h id %0d required 1 80 22 2",
            tile_qvalid_o, tile_qaddr_o, tile_qdata_o, tile_qid_o); end
      cyc();
      checks++; if (busy_o !== 2'b00) begin errors++; $display("FAIL two_all_free: got %b required 00", busy_o); end
      do_resp(8'd3, 32'h0, 1'b0);
      do_resp(8'd4, 32'h0, 1'b0);
   endtask

   task automatic test_back_to_back();
      // slot0 Owner+SC, slot1 Succ; SuccUpdate for slot0 and SC for slot1 in one cycle.
      do_req(32'h40, LR, 8'd1);
      do_req(32'h80, LR, 8'd2);
      do_resp(8'd1, 32'h0, 1'b0);
      do_resp(8'd2, 32'h033, 1'b1);
      do_req(32'h40, SC, 8'd7);
      snitch_qaddr_i = 32'h80; snitch_qamo_i = SC; snitch_qid_i = 8'd8; snitch_qvalid_i = 1'b1;
      tile_pid_i = 8'd7; tile_pdata_i = 32'h044; tile_plrwait_i = 1'b1; tile_pvalid_i = 1'b1;
      cyc();
      snitch_qvalid_i = 1'b0; tile_pvalid_i = 1'b0;
      #1;
      checks++; if (busy_o !== 2'b11 || tile_qaddr_o !== 32'h40 || tile_qid_o !== 8'd7 || tile_qdata_o !== 32'h044)
         begin errors++; $display("FAIL b2b_first: got busy %b addr %h id %0d data %h required 11 40 7 44",
            busy_o, tile_qaddr_o, tile_qid_o, tile_qdata_o); end
      cyc();
      checks++; if (busy_o !== 2'b10 || tile_qaddr_o !== 32'h80 || tile_qid_o !== 8'd2 || tile_qdata_o !== 32'h033)
         begin errors++; $display("FAIL b2b_second: got busy %b addr %h id %0d data %h required 10 80 2 33",
            busy_o, tile_qaddr_o, tile_qid_o, tile_qdata_o); end
      cyc();
      checks++; if (busy_o !== 2'b00 || tile_qlrwait_o !== 1'b0) begin errors++;
         $display("FAIL b2b_done: got busy %b lrw %b required 00 0", busy_o, tile_qlrwait_o); end
   endtask

   task automatic test_full_stall();
      do_req(32'h40, LR, 8'd1);
      do_req(32'h80, LR, 8'd2);
      do_resp(8'd1, 32'h0, 1'b0);
      do_req(32'h40, SC, 8'd5);
      snitch_qaddr_i = 32'hC0; snitch_qamo_i = LR; snitch_qid_i = 8'd3; snitch_qvalid_i = 1'b1;
      #1;
      checks++; if (snitch_qready_o !== 1'b0) begin errors++; $display("FAIL full_stall0: got ready %b required 0", snitch_qready_o); end
      cyc();
      checks++; if (snitch_qready_o !== 1'b0 || busy_o !== 2'b11) begin errors++;
         $display("FAIL full_stall1: got ready %b busy %b required 0 11", snitch_qready_o, busy_o); end
      do_resp(8'd5, 32'h0, 1'b0);
      #1;
      checks++; if (snitch_qready_o !== 1'b1 || busy_o !== 2'b10) begin errors++;
         $display("FAIL full_freed: got ready %b busy %b required 1 10", snitch_qready_o, busy_o); end
      cyc();
      snitch_qvalid_i = 1'b0;
      checks++; if (busy_o !== 2'b11) begin errors++; $display("FAIL full_accept: got busy %b required 11", busy_o); end
   endtask

   task automatic test_errors();
      apply_reset();
      snitch_qaddr_i = 32'h300; snitch_qamo_i = SC; snitch_qid_i = 8'd9; snitch_qvalid_i = 1'b1;
      #1;
      checks++; if (tile_qvalid_o !== 1'b1 || tile_qaddr_o !== 32'h300 || tile_qamo_o !== SC) begin errors++;
         $display("FAIL err_sc_fwd: got v %b addr %h amo %h required 1 300 d", tile_qvalid_o, tile_qaddr_o, tile_qamo_o); end
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL err_sc_early: got %b required 0", error_o); end
      cyc();
      snitch_qvalid_i = 1'b0;
      checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL err_sc_pulse: got %b required 1", error_o); end
      cyc();
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL err_sc_one_cycle: got %b required 0", error_o); end
      do_req(32'h40, LR, 8'd1);
      do_req(32'h40, LR, 8'd2);
      checks++; if (error_o !== 1'b1 || busy_o !== 2'b01) begin errors++;
         $display("FAIL err_lr_dup: got err %b busy %b required 1 01", error_o, busy_o); end
      do_resp(8'd9, 32'h0, 1'b1);
      checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL err_su_orphan: got %b required 1", error_o); end
      do_resp(8'd1, 32'h5, 1'b1);
      do_req(32'h40, SC, 8'd3);
      tile_qready_i = 1'b0;
      #1;
      checks++; if (tile_qlrwait_o !== 1'b1 || busy_o !== 2'b01) begin errors++;
         $display("FAIL err_in_wake: got lrw %b busy %b required 1 01", tile_qlrwait_o, busy_o); end
      rst_ni = 1'b0;
      #1;
      checks++; if (busy_o !== 2'b00 || tile_qlrwait_o !== 1'b0 || error_o !== 1'b0) begin errors++;
         $display("FAIL err_mid_reset: got busy %b lrw %b err %b required 00 0 0", busy_o, tile_qlrwait_o, error_o); end
      cyc();
      rst_ni = 1'b1; tile_qready_i = 1'b1;
      cyc();
      checks++; if (busy_o !== 2'b00 || tile_qvalid_o !== 1'b0) begin errors++;
         $display("FAIL err_post_reset: got busy %b qvalid %b required 00 0", busy_o, tile_qvalid_o); end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_lr_normal();
      test_wakeup();
      test_two_slots();
      test_back_to_back();
      test_full_stall();
      test_errors();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lrwait_mqnode.md
# lrwait_mqnode

Multi-slot successor of the single-reservation LRWait queue node. It sits between a Snitch core and the tile interconnect, is transparent to ordinary traffic, and tracks up to `NumSlots` concurrent LRWait/SCWait reservations to different addresses. Each slot holds its successor metadata; after the matching SCWait it injects the WakeUp that passes the lock down the distributed queue. Arbitration between slots is round-robin.

## Interface
- `NumSlots`, 2: concurrent reservations; ≥1.
- `MetaWidth`, 12: successor-metadata bits carried in `tile_pdata_i`/`tile_qdata_o` LSBs; ≤ `DataWidth`.
- `AddrWidth`, 32: address width.
- `DataWidth`, 32: data width.
- `meta_id_t`, `snitch_pkg::meta_id_t`: request/response ID type.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `snitch_qaddr_i`/`qwrite_i`/`qamo_i[3:0]`/`qdata_i`/`qstrb_i[3:0]`/`qid_i`/`qvalid_i` in; `snitch_qready_o` out 1: core request channel.
- `snitch_pdata_o`/`perror_o`/`pid_o`/`pvalid_o` out; `snitch_pready_i` in 1: core response channel.
- `tile_qaddr_o`/`qwrite_o`/`qamo_o`/`qdata_o`/`qstrb_o`/`qid_o`/`qlrwait_o`/`qvalid_o` out; `tile_qready_i` in 1: interconnect request channel.
- `tile_pdata_i`/`perror_i`/`pid_i`/`plrwait_i`/`pvalid_i` in; `tile_pready_o` out 1: interconnect response channel.
- `busy_o` out `NumSlots`: slot i is not Free.
- `error_o` out 1: one-cycle protocol-violation pulse.

## Operation
- Slot record: `state`, `addr`, `id`, `meta`, `sc_seen`. AMO codes: LRWAIT = 4'hC, SCWAIT = 4'hD.
- Slot states: Free, Pending, Owner, Succ, Wake.
- Free → Pending on an LRWAIT request handshake. The request goes to the lowest-index Free slot; the slot stores `addr` and `id`.
  - If no slot is Free, an LRWAIT is stalled: `snitch_qready_o` = 0.
  - An LRWAIT whose address matches a non-Free slot is passed through without allocation and pulses `error_o`.
- Pending → Owner on handshake of a normal response (`plrwait` = 0) with `pid` = slot `id`. Pending → Succ on a SuccUpdate (`plrwait` = 1, `pid` = `id`); the slot stores `meta` = `pdata[MetaWidth-1:0]`.
- Owner:
  - An SCWAIT handshake whose address equals the slot `addr` sets `sc_seen` and sets `id` to the SC's `qid`.
  - A SuccUpdate stores `meta` and moves to Wake if `sc_seen` is set or an SC handshakes in the same cycle; otherwise it moves to Succ.
  - SC response handshake (`pid` = `id`, `plrwait` = 0) → Free.
- Succ → Wake on the address-matching SCWAIT handshake. The SC itself is forwarded unchanged.
- Wake: the slot requests WakeUp injection. On `tile_qready_i` the slot → Free and clears `sc_seen`.
- WakeUp beat fields: `qamo` = LRWAIT, `qaddr` = slot `addr`, `qid` = slot `id`, `qlrwait` = 1, `qwrite` = 0, `qstrb` = 0, `qdata` = zero-extended `meta`.
- Injection priority: when any slot is in Wake, the WakeUp owns the tile request port and `snitch_qready_o` = 0.
  - Among multiple Wake slots, the grant is round-robin starting after the last granted slot.
  - A granted WakeUp holds `qvalid` with stable fields until `tile_qready_i`.
- Pass-through (no Wake slot): tile request fields equal the core request fields, `tile_qlrwait_o` = 0, `tile_qvalid_o` = `snitch_qvalid_i`, `snitch_qready_o` = `tile_qready_i` (subject to the LRWAIT stall).
- Responses with `plrwait` = 0 pass through combinationally, including `tile_pready_o` = `snitch_pready_i`.
- SuccUpdates are consumed: `tile_pready_o` = 1, `snitch_pvalid_o` = 0. A SuccUpdate matching no Pending/Owner slot is dropped and pulses `error_o`.
- An SCWAIT matching no Owner/Succ slot with `sc_seen` = 0 is passed through and pulses `error_o`.

## Timing
- Reset: all slots Free, registers cleared, round-robin pointer 0, `busy_o` = 0, `error_o` = 0.
  - All request/response outputs follow their combinational pass-through of inputs; `tile_qlrwait_o` = 0.
- Reset asserted mid-operation discards all reservations and any WakeUp in flight.
- Pass-through paths have zero latency; slot state updates at the next clock edge.
- SC handshake in cycle N on a Succ slot: WakeUp `qvalid` appears in N+1 if uncontended. Same for a SuccUpdate arriving after the SC in Owner.
- A request and a response handled in the same cycle are both processed; the request effect is visible to the SuccUpdate decision.
- `error_o` is registered: it is high in the cycle after the offending handshake.

## Test plan
- Plain load `addr` = 0x100, `id` = 3 → forwarded unchanged, `qlrwait` = 0, `busy_o` = 0.
- LRWAIT 0x40 id 1, normal resp id 1, SCWAIT 0x40 id 2, resp id 2 → `busy_o` goes 01 → 00; no WakeUp issued.
- LRWAIT 0x40 id 1, SuccUpdate id 1 with `pdata` = 0x2A5, SCWAIT 0x40 → the cycle after the SC handshake: WakeUp `qamo` = 0xC, `qaddr` = 0x40, `qdata` = 0x2A5, `qlrwait` = 1; `snitch_qready_o` = 0 until `tile_qready_i`.
- Two slots at 0x40 and 0x80, both SuccUpdated, SCs in the same cycle window → two WakeUps in consecutive grants, slot0 first then slot1; hold fields under `tile_qready_i` = 0 for 3 cycles.
- All `NumSlots` slots busy, a third LRWAIT → `snitch_qready_o` = 0 until a slot frees, then accepted.
- SCWAIT 0x300 with no reservation → forwarded, `error_o` = 1 for exactly one cycle; then `rst_ni` low mid-Wake → `busy_o` = 0, `tile_qlrwait_o` = 0.
